carry_chain_counter: RTL and testbench

CARRY_CHAIN_COUNTER -- requirements
Module: carry_chain_counter

---
 rtl/carry_chain_counter.sv | 123 ++++++++++++
 tb/tb_carry_chain_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/carry_chain_counter.sv
// Up/down counter built from an explicit ripple carry chain.
// Each bit is one propagate / carry-mux / sum-xor slice. The carry out of
// the top slice is high exactly when the count sits at the terminal value
// for the selected direction:
//   - all-ones when counting up
//   - zero when counting down
// That carry is therefore both the wrap event and the terminal-count detect.
// With ONESHOT=1 the counter halts at terminal count instead of wrapping,
// and stays halted until LOAD or CLR.

// One counter bit: propagate, carry mux and sum xor.
module CarryChainSlice (
    input  logic q_i,
    input  logic carry_i,
    input  logic up_i,
    output logic sum_o,
    output logic carry_o
);

    logic propagate;

    // Counting up, a carry ripples through ones.
    // Counting down, a borrow ripples through zeros.
    always_comb begin
        propagate = up_i ? q_i : ~q_i;
        carry_o   = propagate ? carry_i : 1'b0;
        sum_o     = q_i ^ carry_i;
    end

endmodule

module carry_chain_counter #(
    parameter int WIDTH   = 8,   // legal range 2..32
    parameter int ONESHOT = 0    // 0 = free-running wrap, 1 = halt at terminal count
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             DONE
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [0:0]       state_q, state_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             wrapEvent;
    logic             stepEn;

    // The chain always adds or subtracts exactly one, so it is seeded with a carry-in of 1.
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : gSlice
            CarryChainSlice uSlice (
                .q_i     (q_q[i]),
                .carry_i (carry[i]),
                .up_i    (UP),
                .sum_o   (sum[i]),
                .carry_o (carry[i+1])
            );
        end
    endgenerate

    // All slices propagating means Q is at the terminal value for the current UP.
    assign wrapEvent = carry[WIDTH];

    // A count step needs CE, no competing LOAD, and the counter not halted.
    assign stepEn = CE & ~LOAD & (state_q == ST_RUN);

    // Next-state selection: LOAD wins over counting.
    // TC is only raised by a step taken at terminal count.
    always_comb begin
        q_d     = q_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        state_d = state_q;
        if (LOAD) begin
            q_d     = D;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else if (stepEn) begin
            tc_d = wrapEvent;
            if (wrapEvent && (ONESHOT != 0)) begin
                state_d = ST_HALT;
                done_d  = 1'b1;
            end else begin
                q_d = sum;
            end
        end
    end

    // State registers; CLR clears everything at once without waiting for a clock.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            q_q     <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            q_q     <= q_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign Q    = q_q;
    assign TC   = tc_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_carry_chain_counter.sv
// Scoreboard bench for carry_chain_counter at WIDTH=4.
// A free-running instance and a one-shot instance are driven with identical
// stimulus. Expected outputs come from an arithmetic model of the counter
// and are checked by a separate monitor process.
module tb_carry_chain_counter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic         done;
    } obs_t;

    typedef struct packed {
        obs_t freeRun;
        obs_t oneShot;
    } exp_t;

    logic         CLK = 1'b0;
    logic         CLR;
    logic         CE;
    logic         LOAD;
    logic [W-1:0] D;
    logic         UP;

    logic [W-1:0] qFree, qOne;
    logic         tcFree, tcOne, doneFree, doneOne;

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t expQ[$];

    // Model state, index 0 = free-running, index 1 = one-shot.
    int mCnt[2];
    bit mHalt[2];
    bit mTc[2];
    bit mDone[2];

    carry_chain_counter #(.WIDTH(W), .ONESHOT(0)) dutFree (
        .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .D(D), .UP(UP),
        .Q(qFree), .TC(tcFree), .DONE(doneFree)
    );

    carry_chain_counter #(.WIDTH(W), .ONESHOT(1)) dutOne (
        .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .D(D), .UP(UP),
        .Q(qOne), .TC(tcOne), .DONE(doneOne)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: one clock edge of the counter, expressed as plain arithmetic.
    task automatic modelEdge(input int k, input bit clr, input bit load, input bit ce,
                             input bit up, input int d);
        int term;
        if (!clr) begin
            mCnt[k] = 0; mTc[k] = 0; mDone[k] = 0; mHalt[k] = 0;
        end else if (load) begin
            mCnt[k] = d; mTc[k] = 0; mDone[k] = 0; mHalt[k] = 0;
        end else if (ce && !mHalt[k]) begin
            term   = up ? MAX : 0;
            mTc[k] = (mCnt[k] == term);
            if (mTc[k] && k == 1) begin
                mHalt[k] = 1;
                mDone[k] = 1;
            end else if (up) begin
                mCnt[k] = (mCnt[k] + 1) % (MAX + 1);
            end else begin
                mCnt[k] = (mCnt[k] + MAX) % (MAX + 1);
            end
        end else begin
            mTc[k] = 0;
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the next edge.
    // When CLR is dropped, the outputs are checked at once, before any edge.
    task automatic applyStimulus(input bit clr, input bit load, input bit ce,
                                 input bit up, input int d);
        exp_t e;
        @(negedge CLK);
        CLR  = clr;
        LOAD = load;
        CE   = ce;
        UP   = up;
        D    = W'(d);
        for (int k = 0; k < 2; k++) modelEdge(k, clr, load, ce, up, d);
        e.freeRun.q    = W'(mCnt[0]);
        e.freeRun.tc   = mTc[0];
        e.freeRun.done = mDone[0];
        e.oneShot.q    = W'(mCnt[1]);
        e.oneShot.tc   = mTc[1];
        e.oneShot.done = mDone[1];
        expQ.push_back(e);
        if (!clr) begin
            #1;
            checkOutput("async_clr_q_free",    int'(qFree),    0);
            checkOutput("async_clr_tc_free",   int'(tcFree),   0);
            checkOutput("async_clr_done_free", int'(doneFree), 0);
            checkOutput("async_clr_q_one",     int'(qOne),     0);
            checkOutput("async_clr_tc_one",    int'(tcOne),    0);
            checkOutput("async_clr_done_one",  int'(doneOne),  0);
        end
    endtask

    // Monitor: compares the DUT outputs with the oldest expectation just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("q_free",    int'(qFree),    int'(e.freeRun.q));
                checkOutput("tc_free",   int'(tcFree),   int'(e.freeRun.tc));
                checkOutput("done_free", int'(doneFree), int'(e.freeRun.done));
                checkOutput("q_one",     int'(qOne),     int'(e.oneShot.q));
                checkOutput("tc_one",    int'(tcOne),    int'(e.oneShot.tc));
                checkOutput("done_one",  int'(doneOne),  int'(e.oneShot.done));
            end
        end
    end

    initial begin
        bit upR;
        for (int k = 0; k < 2; k++) begin
            mCnt[k] = 0; mHalt[k] = 0; mTc[k] = 0; mDone[k] = 0;
        end
        CLR = 1'b0; LOAD = 1'b0; CE = 1'b1; UP = 1'b1; D = '0;
        #1;
        checkOutput("reset_q_free",    int'(qFree),    0);
        checkOutput("reset_tc_free",   int'(tcFree),   0);
        checkOutput("reset_done_free", int'(doneFree), 0);
        checkOutput("reset_q_one",     int'(qOne),     0);
        checkOutput("reset_done_one",  int'(doneOne),  0);

        // Held reset ignores CE, then count up to 9 and drop CLR between edges.
        applyStimulus(0, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 5);
        applyStimulus(1, 0, 1, 1, 0);

        // Free-running wrap upward from 14.
        applyStimulus(1, 1, 0, 1, 14);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 0);

        // Wrap downward from 1.
        applyStimulus(1, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0);

        // One-shot halt at 15, ignore CE while halted, then reload and resume.
        applyStimulus(1, 1, 0, 1, 13);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 3);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 1, 0);

        // LOAD beats CE, CE=0 holds, UP toggling takes effect immediately.
        applyStimulus(1, 1, 0, 1, 2);
        applyStimulus(1, 1, 1, 1, 7);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0);

        // Down from zero straight after reset: the one-shot halts at 0 on the first step.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);

        // Randomized traffic with a sticky direction, so terminal counts are reached.
        upR = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) upR = ~upR;
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0,
                          upR,
                          int'($urandom_range(0, MAX)));
        end

        repeat (3) @(posedge CLK);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
